// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//   Data-memory responder for the MEM stage of the multi-cycle CPU. Services
//   the control unit's active-low RD/WR strobes against a byte-addressed,
//   big-endian word store. Each accepted access takes LAT wait cycles plus
//   one access cycle. Every request ends with a one-cycle Done pulse, and
//   ErrCode reports the outcome.
//
// Parameters
//   DEPTH   memory size in bytes (multiple of 4)
//   LAT     wait cycles inserted before an access completes (0..7)
//
// Ports
//   CLK      in   1   clock, rising edge
//   RST      in   1   asynchronous active-low reset
//   DAddr    in   32  byte address of the access
//   DataIn   in   32  write data
//   RD       in   1   read strobe, active-low (1/z/x are inactive)
//   WR       in   1   write strobe, active-low (1/z/x are inactive)
//   DataOut  out  32  registered read data, holds across writes/errors
//   Busy     out  1   high while an accepted access is in progress
//   Done     out  1   one-cycle completion pulse (success or error)
//   ErrCode  out  2   00 ok, 01 misaligned, 10 out of range, 11 RD/WR conflict
//
// State   | meaning
// IDLE    | waiting for a strobe; errors are answered here in one edge
// WAIT    | access accepted, counting down the LAT wait cycles
// ACCESS  | perform the latched read/write, pulse Done, return to IDLE
// ---------------------------------------------------------------------------
module data_mem_responder #(
  parameter int DEPTH = 128,
  parameter int LAT   = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] DAddr,
  input  logic [31:0] DataIn,
  input  logic        RD,
  input  logic        WR,
  output logic [31:0] DataOut,
  output logic        Busy,
  output logic        Done,
  output logic [1:0]  ErrCode
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] LAST_ADDR = 32'(DEPTH - 4);
  localparam logic [2:0]  LAT_INIT  = 3'(LAT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [2:0]      cnt, cnt_n;
  logic            op_wr, op_wr_n;
  logic [AW-1:0]   addr_q, addr_n;
  logic [31:0]     data_q, data_n;
  logic [31:0]     dout_n;
  logic            busy_n, done_n;
  logic [1:0]      err_n;
  logic            mem_we;
  logic            rd_req, wr_req;

  // Memory powers up cleared and is deliberately outside the reset domain.
  logic [7:0] mem [DEPTH] = '{default: 8'h00};

  // Only a clean logic 0 asserts a strobe. Written as if/else so that an
  // x or z strobe evaluates the condition as false and falls to inactive.
  always_comb begin
    rd_req = 1'b0;
    wr_req = 1'b0;
    if (RD == 1'b0) rd_req = 1'b1;
    if (WR == 1'b0) wr_req = 1'b1;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_wr_n = op_wr;
    addr_n  = addr_q;
    data_n  = data_q;
    dout_n  = DataOut;
    busy_n  = Busy;
    err_n   = ErrCode;
    done_n  = 1'b0;
    mem_we  = 1'b0;

    case (state)
      IDLE: begin
        if (rd_req || wr_req) begin
          if (rd_req && wr_req) begin
            err_n  = 2'b11;
            done_n = 1'b1;
          end else if (DAddr[1:0] != 2'b00) begin
            err_n  = 2'b01;
            done_n = 1'b1;
          end else if (DAddr > LAST_ADDR) begin
            err_n  = 2'b10;
            done_n = 1'b1;
          end else begin
            op_wr_n = wr_req;
            addr_n  = DAddr[AW-1:0];
            data_n  = DataIn;
            err_n   = 2'b00;
            busy_n  = 1'b1;
            cnt_n   = LAT_INIT;
            state_n = (LAT > 0) ? WAIT : ACCESS;
          end
        end
      end

      WAIT: begin
        cnt_n = cnt - 3'd1;
        if (cnt == 3'd1) state_n = ACCESS;
      end

      ACCESS: begin
        if (op_wr) begin
          mem_we = 1'b1;
        end else begin
          dout_n = {mem[addr_q], mem[addr_q + AW'(1)],
                    mem[addr_q + AW'(2)], mem[addr_q + AW'(3)]};
        end
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      op_wr   <= 1'b0;
      addr_q  <= '0;
      data_q  <= 32'h0;
      DataOut <= 32'h0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      ErrCode <= 2'b00;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      op_wr   <= op_wr_n;
      addr_q  <= addr_n;
      data_q  <= data_n;
      DataOut <= dout_n;
      Busy    <= busy_n;
      Done    <= done_n;
      ErrCode <= err_n;
    end
  end

  // The write only happens from ACCESS. Reset forces IDLE, so a pending
  // write that is interrupted by reset never reaches the array.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[addr_q]           <= data_q[31:24];
      mem[addr_q + AW'(1)]  <= data_q[23:16];
      mem[addr_q + AW'(2)]  <= data_q[15:8];
      mem[addr_q + AW'(3)]  <= data_q[7:0];
    end
  end

endmodule
